bcd_multi_counter: RTL and testbench

- Parametrised multi-digit modulo counter, default decimal (BCD), built as a chain of single-digit stages with ripple carry/borrow.
- Adds up/down direction, a wrap or saturate mode, a full-width synchronous load, and a registered wrap pulse.
- Feeds score, timer, distance and speed displays; each digit drives one 7-segment decoder.

---
 rtl/counter_pkg.sv | 29 ++
 rtl/counter_digit.sv | 62 ++++++
 rtl/bcd_multi_counter.sv | 104 ++++++++++
 tb/tb_bcd_multi_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared constants, types and helpers for the multi-digit modulo counter.
//   MAX_DIGITS / MAX_RADIX : upper bounds on the counter parameters
//   step_dir_t             : step direction handed to every digit stage
//   clamp_digit()          : forces an out-of-range load digit to radix-1
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_RADIX  = 16;
    localparam int MAX_DW     = $clog2(MAX_RADIX);

    typedef enum logic {
        STEP_UP   = 1'b0,
        STEP_DOWN = 1'b1
    } step_dir_t;

    // Digits are handled at the widest supported width so one helper serves
    // every radix; callers resize the result to their own digit width.
    function automatic logic [MAX_DW-1:0] clamp_digit(input logic [MAX_DW-1:0] value,
                                                      input int                radix);
        if (int'(value) >= radix) begin
            return MAX_DW'(radix - 1);
        end
        return value;
    endfunction

endpackage

// File: rtl/counter_digit.sv
// ---------------------------------------------------------------------------
// counter_digit
// One modulo-RADIX digit stage of the ripple counter.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   enable_i       : global enable; low holds the digit (load included)
//   load_i         : synchronous load of load_val_i (already clamped)
//   load_val_i     : value loaded when load_i is high
//   step_in_i      : advance/retreat this digit on the current edge
//   dir_i          : STEP_UP or STEP_DOWN
//   digit_o        : current digit value
//   term_o         : digit is at its terminal value for dir_i
//                    (RADIX-1 going up, 0 going down)
// ---------------------------------------------------------------------------
module counter_digit
    import counter_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int DW    = $clog2(RADIX)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic            load_i,
    input  logic [DW-1:0]   load_val_i,
    input  logic            step_in_i,
    input  step_dir_t       dir_i,
    output logic [DW-1:0]   digit_o,
    output logic            term_o
);

    localparam logic [DW-1:0] DIGIT_MAX = DW'(RADIX - 1);

    logic [DW-1:0] digit_q;
    logic [DW-1:0] digit_d;

    assign term_o = (dir_i == STEP_UP) ? (digit_q == DIGIT_MAX) : (digit_q == '0);

    // Terminal digits roll over; everything else moves by one.
    always_comb begin
        digit_d = digit_q;
        if (dir_i == STEP_UP) begin
            digit_d = term_o ? '0 : digit_q + DW'(1);
        end else begin
            digit_d = term_o ? DIGIT_MAX : digit_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            digit_q <= '0;
        end else if (enable_i) begin
            if (load_i) begin
                digit_q <= load_val_i;
            end else if (step_in_i) begin
                digit_q <= digit_d;
            end
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_multi_counter.sv
// ---------------------------------------------------------------------------
// bcd_multi_counter
// Multi-digit modulo counter (BCD by default) with up/down, wrap/saturate,
// full-width load and a registered whole-counter wrap pulse.
//   clk_i          : clock, rising edge
//   reset_i        : asynchronous active-high reset, clears count and carry
//   enable_i       : global enable; low holds everything
//   load_n_i       : active-low synchronous load of init_i
//   enable_cnt_i   : step request
//   down_i         : 0 count up, 1 count down
//   saturate_i     : 0 wrap at the limit, 1 hold at the limit
//   init_i         : load value, digit i at [i*DW +: DW]
//   count_o        : counter value, digit 0 least significant
//   carry_out_o    : one-cycle pulse on a whole-counter wrap
//   at_max_o       : every digit is RADIX-1
//   at_zero_o      : every digit is 0
// ---------------------------------------------------------------------------
module bcd_multi_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic                         load_n_i,
    input  logic                         enable_cnt_i,
    input  logic                         down_i,
    input  logic                         saturate_i,
    input  logic [DIGITS*$clog2(RADIX)-1:0] init_i,
    output logic [DIGITS*$clog2(RADIX)-1:0] count_o,
    output logic                         carry_out_o,
    output logic                         at_max_o,
    output logic                         at_zero_o
);

    localparam int DW = $clog2(RADIX);
    localparam logic [DW-1:0] DIGIT_MAX = DW'(RADIX - 1);

    step_dir_t         dir;
    logic [DIGITS:0]   chain;      // chain[i]: all digits below i are terminal
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_zero;
    logic              all_term;
    logic              step_req;
    logic              carry_q;
    logic              carry_d;

    assign dir      = down_i ? STEP_DOWN : STEP_UP;
    assign chain[0] = 1'b1;
    assign all_term = chain[DIGITS];

    // Saturation simply suppresses the step when the whole counter sits at
    // the limit for the current direction; otherwise the ripple wraps all
    // digits naturally.
    assign step_req = enable_cnt_i & ~(saturate_i & all_term);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [DW-1:0] load_val;

            assign load_val = DW'(clamp_digit(MAX_DW'(init_i[gi*DW +: DW]), RADIX));

            counter_digit #(
                .RADIX (RADIX),
                .DW    (DW)
            ) u_digit (
                .clk_i      (clk_i),
                .reset_i    (reset_i),
                .enable_i   (enable_i),
                .load_i     (~load_n_i),
                .load_val_i (load_val),
                .step_in_i  (step_req & chain[gi]),
                .dir_i      (dir),
                .digit_o    (count_o[gi*DW +: DW]),
                .term_o     (term[gi])
            );

            assign chain[gi+1] = chain[gi] & term[gi];
            assign is_max[gi]  = (count_o[gi*DW +: DW] == DIGIT_MAX);
            assign is_zero[gi] = (count_o[gi*DW +: DW] == '0);
        end
    endgenerate

    // Wrap pulse only for a real step taken at the limit in wrap mode;
    // hold, load and disable all force it low.
    assign carry_d = enable_i & load_n_i & enable_cnt_i & all_term & ~saturate_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out_o = carry_q;
    assign at_max_o    = &is_max;
    assign at_zero_o   = &is_zero;

endmodule

// File: tb/tb_bcd_multi_counter.sv
module tb_bcd_multi_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load_n;
    logic        enable_cnt;
    logic        down;
    logic        saturate;
    logic [15:0] init;

    logic [7:0]  count2;
    logic        carry2, at_max2, at_zero2;
    logic [15:0] count4;
    logic        carry4, at_max4, at_zero4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          which;
        logic [15:0] count;
        logic        carry;
    } exp_t;

    exp_t sb[$];

    bcd_multi_counter #(.DIGITS(2), .RADIX(10)) u_dut2 (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .load_n_i     (load_n),
        .enable_cnt_i (enable_cnt),
        .down_i       (down),
        .saturate_i   (saturate),
        .init_i       (init[7:0]),
        .count_o      (count2),
        .carry_out_o  (carry2),
        .at_max_o     (at_max2),
        .at_zero_o    (at_zero2)
    );

    bcd_multi_counter #(.DIGITS(4), .RADIX(10)) u_dut4 (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .load_n_i     (load_n),
        .enable_cnt_i (enable_cnt),
        .down_i       (down),
        .saturate_i   (saturate),
        .init_i       (init),
        .count_o      (count4),
        .carry_out_o  (carry4),
        .at_max_o     (at_max4),
        .at_zero_o    (at_zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic edge_expect(input string tag, input int which,
                               input logic [15:0] exp_count, input logic exp_carry);
        exp_t e;
        exp_t got;
        e.tag = tag; e.which = which; e.count = exp_count; e.carry = exp_carry;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (got.which == 2) begin
            check({got.tag, ".count"}, {8'h00, count2}, got.count);
            check({got.tag, ".carry"}, {15'h0, carry2}, {15'h0, got.carry});
        end else begin
            check({got.tag, ".count"}, count4, got.count);
            check({got.tag, ".carry"}, {15'h0, carry4}, {15'h0, got.carry});
        end
        $display("step %s dut%0d count2=%h count4=%h carry2=%b carry4=%b",
                 got.tag, got.which, count2, count4, carry2, carry4);
    endtask

    task automatic load4(input logic [15:0] value, input logic [15:0] exp);
        enable = 1'b1; load_n = 1'b0; enable_cnt = 1'b0; init = value;
        edge_expect("load", 4, exp, 1'b0);
        load_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_bcd;
        reset = 1'b1; enable = 1'b0; load_n = 1'b1; enable_cnt = 1'b0;
        down = 1'b0; saturate = 1'b0; init = 16'h0000;
        #3;
        check("reset.count2", {8'h00, count2}, 16'h0000);
        check("reset.count4", count4, 16'h0000);
        check("reset.carry4", {15'h0, carry4}, 16'h0000);
        check("reset.at_zero4", {15'h0, at_zero4}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;

        // Two-digit BCD up-count across a full wrap and one edge past it.
        enable = 1'b1; enable_cnt = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            exp_bcd = {8'h00, 4'((k % 100) / 10), 4'(k % 10)};
            edge_expect($sformatf("up2_%0d", k), 2, exp_bcd, (k == 100));
        end

        // Decade borrow/carry on four digits.
        load4(16'h0199, 16'h0199);
        enable_cnt = 1'b1; down = 1'b0;
        edge_expect("up_0199", 4, 16'h0200, 1'b0);
        down = 1'b1;
        edge_expect("down_0200", 4, 16'h0199, 1'b0);

        // Down limit, wrap then saturate.
        load4(16'h0000, 16'h0000);
        enable_cnt = 1'b1; down = 1'b1; saturate = 1'b0;
        edge_expect("down_wrap", 4, 16'h9999, 1'b1);
        check("down_wrap.at_max", {15'h0, at_max4}, 16'h0001);
        load4(16'h0000, 16'h0000);
        enable_cnt = 1'b1; down = 1'b1; saturate = 1'b1;
        edge_expect("down_sat", 4, 16'h0000, 1'b0);
        check("down_sat.at_zero", {15'h0, at_zero4}, 16'h0001);

        // Up limit in saturate mode.
        load4(16'h9999, 16'h9999);
        enable_cnt = 1'b1; down = 1'b0; saturate = 1'b1;
        edge_expect("up_sat", 4, 16'h9999, 1'b0);
        saturate = 1'b0;

        // Priority: disable beats load and count; load beats count.
        load4(16'h0042, 16'h0042);
        enable = 1'b0; load_n = 1'b0; enable_cnt = 1'b1; init = 16'h1234;
        edge_expect("disabled", 4, 16'h0042, 1'b0);
        enable = 1'b1;
        edge_expect("load_over_cnt", 4, 16'h1234, 1'b0);
        load_n = 1'b1;

        // Out-of-range load digits clamp to 9.
        load4(16'h0FC5, 16'h0995);

        // Async reset while a wrap pulse is high.
        load4(16'h9999, 16'h9999);
        enable_cnt = 1'b1; down = 1'b0;
        edge_expect("wrap_before_reset", 4, 16'h0000, 1'b1);
        enable_cnt = 1'b0;
        load4(16'h9998, 16'h9998);
        enable_cnt = 1'b1;
        edge_expect("to_9999", 4, 16'h9999, 1'b0);
        edge_expect("wrap_pulse", 4, 16'h0000, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_reset.carry", {15'h0, carry4}, 16'h0000);
        reset = 1'b0;
        enable_cnt = 1'b0;
        load4(16'h9998, 16'h9998);
        #2 reset = 1'b1;
        #1;
        check("async_reset.count", count4, 16'h0000);
        check("async_reset.carry2", {15'h0, carry4}, 16'h0000);
        reset = 1'b0;
        enable_cnt = 1'b1; down = 1'b0; saturate = 1'b0;
        edge_expect("after_reset", 4, 16'h0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
